counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised multi-channel event counter bank. It replaces the fixed two-channel, 64-bit selectable counter with CHANNELS independent counters of WIDTH bits. A single select steers count, load and clear operations to one channel per cycle, and every channel remains continuously observable. Counters count up or down and flag wrap-around per channel. The block sits beside the datapath as a general-purpose statistics/profiling resource.

## Interface
- WIDTH, 64, bit width of each counter (≥ 2).
- CHANNELS, 2, number of counters (≥ 2).
- SEL_W, $clog2(CHANNELS), select width; derived, never overridden.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- En  in  1  count enable for the selected channel.
- Slt  in  SEL_W  channel select for En/Load/Clear.
- Dir  in  1  1 = count up, 0 = count down.
- Load  in  1  load LoadVal into the selected channel.
- LoadVal  in  WIDTH  load value.
- Clear  in  1  zero the selected channel and its flag.
- Count  out  CHANNELS*WIDTH  all counters flattened; channel k at [k*WIDTH +: WIDTH].
- CountSel  out  WIDTH  value of channel Slt.
- Wrap  out  CHANNELS  sticky per-channel wrap/saturate flag.

## Operation
- The operation each cycle is determined solely by the selected channel. Unselected channels hold their value.
- Priority at the rising edge: Reset_n = 0 > Clear > Load > En. Lower-priority requests in the same cycle are ignored.
- Reset: all counters are 0 and all Wrap bits are 0.
- Clear: selected counter = 0 and Wrap[Slt] = 0.
- Load: selected counter = LoadVal and Wrap[Slt] = 0.
- En with Dir = 1: counter + 1. Max (all ones) → 0, and Wrap[Slt] is set.
- En with Dir = 0: counter − 1. 0 → max, and Wrap[Slt] is set.
- Wrap bits are sticky. Only reset, Clear or Load of that channel clears them.
- En = 0 with no Load or Clear: nothing changes.
- Slt ≥ CHANNELS (non-power-of-two CHANNELS): no channel is modified and CountSel = 0.
- Arithmetic is modulo 2^WIDTH. There is no carry output.

## Timing
- Counters and Wrap are registered. A change is visible on Count and Wrap in the cycle after the enabling edge, so latency is 1 clock.
- CountSel is a combinational mux of the registered counters by the current Slt, with zero additional latency.
- Back-to-back operations on the same or different channels are allowed every cycle with no bubbles.
- Reset asserted mid-operation overrides everything at the next edge. The first count after Reset_n rises takes effect one edge later.
- Changing Slt between cycles retargets the operation immediately. No pending state is carried.

## Configuration
- COUNTER_BANK_SAT_EN defined: counters saturate instead of wrapping.
  - Up at max holds max and sets Wrap.
  - Down at 0 holds 0 and sets Wrap.
  - Wrap then means "saturated".
- COUNTER_BANK_SAT_EN undefined: modulo wrap-around as described above.
- All other behaviour is identical in both builds.

## Structure
- Shared package counter_bank_pkg holds:
  - DIR_UP = 1 and DIR_DOWN = 0.
  - Operation encoding OP_NONE, OP_CNT, OP_LOAD, OP_CLR, as a 2-bit enum.
  - Default WIDTH and CHANNELS constants.
- Top level decodes priority into an op, generates the per-channel select, and builds the CountSel mux.
- One sub-module, counter_bank_chan: a single WIDTH-bit counter with its Wrap flag. It has inputs Clk, Reset_n, sel, op, Dir and LoadVal, and is instantiated CHANNELS times in a generate loop.

## Test plan
All scenarios use WIDTH = 8, CHANNELS = 4.
- Reset_n = 0 for 2 cycles, then release → Count = 0 and Wrap = 4'b0000. With En = 0 for 5 cycles, nothing changes.
- Slt = 0, En = 1, Dir = 1 for 3 cycles, then Slt = 2 for 2 cycles → ch0 = 3, ch2 = 2, ch1 = ch3 = 0. CountSel follows Slt with no delay.
- Load 8'hFE into ch1, then 3 up-counts → 8'hFF, 8'h00, 8'h01 and Wrap[1] = 1. In the COUNTER_BANK_SAT_EN build: 8'hFF, 8'hFF, 8'hFF with Wrap[1] = 1.
- ch3 = 0, Dir = 0, one En → ch3 = 8'hFF and Wrap[3] = 1 (SAT build: 0 and Wrap[3] = 1). A following Clear → ch3 = 0 and Wrap[3] = 0.
- Same cycle Clear = 1, Load = 1 (LoadVal = 8'h55), En = 1 on ch2 = 7 → ch2 = 0. Then Load with En → ch2 = 8'h55, not 8'h56.
- Counts running on ch0 = 10 and ch1 = 20, assert Reset_n = 0 together with En = 1 → all zero next edge. With Wrap set on any channel, reset clears all Wrap bits.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared constants and operation encoding for counter_bank.
package counter_bank_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_CHANNELS = 2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Operation applied to the selected channel, already priority-resolved.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_CNT  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

endpackage

// File: rtl/counter_bank_if.sv
// counter_bank_if: control/observation bundle of the counter bank.
// master = the agent issuing operations, slave = the counter bank.
interface counter_bank_if #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 2
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      en;
    logic [SEL_W-1:0]          slt;
    logic                      dir;
    logic                      load;
    logic [WIDTH-1:0]          loadval;
    logic                      clear;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [WIDTH-1:0]          countsel;
    logic [CHANNELS-1:0]       wrap;

    modport master (
        output en, slt, dir, load, loadval, clear,
        input  count, countsel, wrap
    );

    modport slave (
        input  en, slt, dir, load, loadval, clear,
        output count, countsel, wrap
    );
endinterface

// File: rtl/counter_bank_chan.sv
// counter_bank_chan: one WIDTH-bit up/down counter with its sticky wrap flag.
// Build option: COUNTER_BANK_SAT_EN makes the counter saturate at 0 / max
// instead of wrapping; the flag then means "saturated".
module counter_bank_chan
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sel,
    input  op_e              op,
    input  logic             dir,
    input  logic [WIDTH-1:0] loadval,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    // Counter and flag update; only the selected channel reacts to op.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (sel) begin
            case (op)
                OP_CLR: begin
                    cnt  <= '0;
                    wrap <= 1'b0;
                end
                OP_LOAD: begin
                    cnt  <= loadval;
                    wrap <= 1'b0;
                end
                OP_CNT: begin
                    if (dir == DIR_UP) begin
                        if (&cnt) begin
                            wrap <= 1'b1;
`ifdef COUNTER_BANK_SAT_EN
                            cnt  <= cnt;
`else
                            cnt  <= '0;
`endif
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end else begin
                        if (cnt == '0) begin
                            wrap <= 1'b1;
`ifdef COUNTER_BANK_SAT_EN
                            cnt  <= '0;
`else
                            cnt  <= '1;
`endif
                        end else begin
                            cnt <= cnt - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    cnt  <= cnt;
                    wrap <= wrap;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit event counters steered by one
// select. Build option COUNTER_BANK_SAT_EN (handled in counter_bank_chan)
// switches every channel from wrap-around to saturation.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic              clk,
    input  logic              reset_n,
    counter_bank_if.slave     bus
);

    localparam int SEL_W = $clog2(CHANNELS);

    op_e                            op;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt;
    logic [CHANNELS-1:0]            wrap;

    // Resolve Clear > Load > En into a single operation for this cycle.
    always_comb begin
        op = OP_NONE;
        if (bus.clear)     op = OP_CLR;
        else if (bus.load) op = OP_LOAD;
        else if (bus.en)   op = OP_CNT;
    end

    // One counter per channel; an out-of-range select matches no channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        counter_bank_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .sel     (bus.slt == SEL_W'(k)),
            .op      (op),
            .dir     (bus.dir),
            .loadval (bus.loadval),
            .cnt     (cnt[k]),
            .wrap    (wrap[k])
        );
    end

    assign bus.count = cnt;
    assign bus.wrap  = wrap;

    // Zero-latency view of the selected channel; 0 when nothing matches.
    always_comb begin
        bus.countsel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.slt == SEL_W'(k)) bus.countsel = cnt[k];
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed scenarios plus randomized traffic for counter_bank
// (WIDTH=8, CHANNELS=4), checked against a behavioural model of the bank.
module tb_counter_bank;

    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic reset_n;

    counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int m_cnt  [C];
    bit m_wrap [C];

`ifdef COUNTER_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ch(input int k);
        logic [C*W-1:0] v;
        v = bus.count;
        return int'(v[k*W +: W]);
    endfunction

    // Apply one cycle of inputs, check the combinational select view, then
    // advance the model and check every registered output after the edge.
    task automatic cyc(input bit rn, input bit e, input bit d, input bit ld,
                       input bit cl, input int s, input int lv);
        logic [C-1:0] wv;
        reset_n     = rn;
        bus.en      = e;
        bus.dir     = d;
        bus.load    = ld;
        bus.clear   = cl;
        bus.slt     = 2'(s);
        bus.loadval = 8'(lv);
        #1;
        chk("countsel", 64'(bus.countsel), 64'(m_cnt[s]));
        @(posedge clk);
        if (!rn) begin
            for (int k = 0; k < C; k++) begin m_cnt[k] = 0; m_wrap[k] = 0; end
        end else if (cl) begin
            m_cnt[s] = 0; m_wrap[s] = 0;
        end else if (ld) begin
            m_cnt[s] = lv % 256; m_wrap[s] = 0;
        end else if (e) begin
            if (d) begin
                if (m_cnt[s] == 255) begin
                    m_wrap[s] = 1;
                    m_cnt[s]  = SAT ? 255 : 0;
                end else m_cnt[s] = m_cnt[s] + 1;
            end else begin
                if (m_cnt[s] == 0) begin
                    m_wrap[s] = 1;
                    m_cnt[s]  = SAT ? 0 : 255;
                end else m_cnt[s] = m_cnt[s] - 1;
            end
        end
        #1;
        for (int k = 0; k < C; k++) begin
            chk($sformatf("count[%0d]", k), 64'(ch(k)), 64'(m_cnt[k]));
            wv[k] = m_wrap[k];
        end
        chk("wrap", 64'(bus.wrap), 64'(wv));
    endtask

    task automatic up(input int s);   cyc(1, 1, 1, 0, 0, s, 0);  endtask
    task automatic down(input int s); cyc(1, 1, 0, 0, 0, s, 0);  endtask
    task automatic ld(input int s, input int v); cyc(1, 0, 1, 1, 0, s, v); endtask

    initial begin
        reset_n     = 1'b0;
        bus.en      = 1'b0;
        bus.dir     = 1'b1;
        bus.load    = 1'b0;
        bus.clear   = 1'b0;
        bus.slt     = '0;
        bus.loadval = '0;
        for (int k = 0; k < C; k++) begin m_cnt[k] = 0; m_wrap[k] = 0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_wrap",  64'(bus.wrap),  64'd0);

        // Idle cycles: nothing moves.
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0, i % C, 8'hAA);

        // Counting steered by select.
        repeat (3) up(0);
        repeat (2) up(2);
        chk("ch0_is_3", 64'(ch(0)), 64'd3);
        chk("ch2_is_2", 64'(ch(2)), 64'd2);
        chk("ch1_ch3_0", 64'(ch(1) + ch(3)), 64'd0);

        // Up across max on ch1.
        ld(1, 8'hFE);
        up(1); chk("ch1_ff", 64'(ch(1)), 64'hFF);
        up(1); chk("ch1_wrap_val", 64'(ch(1)), SAT ? 64'hFF : 64'h00);
        up(1); chk("ch1_after", 64'(ch(1)), SAT ? 64'hFF : 64'h01);
        chk("wrap1", 64'(bus.wrap[1]), 64'd1);

        // Down across zero on ch3, then clear.
        down(3);
        chk("ch3_down", 64'(ch(3)), SAT ? 64'h00 : 64'hFF);
        chk("wrap3", 64'(bus.wrap[3]), 64'd1);
        cyc(1, 0, 1, 0, 1, 3, 0);
        chk("ch3_clr", 64'(ch(3)), 64'd0);
        chk("wrap3_clr", 64'(bus.wrap[3]), 64'd0);

        // Priority: Clear beats Load beats En.
        ld(2, 7);
        cyc(1, 1, 1, 1, 1, 2, 8'h55);
        chk("clr_wins", 64'(ch(2)), 64'd0);
        cyc(1, 1, 1, 1, 0, 2, 8'h55);
        chk("load_wins", 64'(ch(2)), 64'h55);

        // Reset during counting clears everything, including sticky flags.
        ld(0, 10);
        ld(1, 20);
        up(0);
        cyc(0, 1, 1, 0, 0, 1, 0);
        chk("rst_mid_count", 64'(bus.count), 64'd0);
        chk("rst_mid_wrap",  64'(bus.wrap),  64'd0);

        // Randomized traffic, biased toward boundary load values.
        for (int i = 0; i < 400; i++) begin
            int lv;
            case ($urandom_range(0, 5))
                0: lv = 8'hFF;
                1: lv = 8'hFE;
                2: lv = 8'h00;
                3: lv = 8'h01;
                default: lv = int'($urandom_range(0, 255));
            endcase
            cyc(($urandom_range(0, 59) != 0),
                ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1,
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, C - 1)),
                lv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
